// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller poll path.
package n64_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        TXSTART,
        TX,
        RX,
        GOOD,
        FAIL
    } poll_state_t;

    localparam int CMD_BITS        = 34;
    localparam int RESP_BITS       = 33;
    localparam int DEF_POLL_PERIOD = 16667;
    localparam int DEF_RX_TIMEOUT  = 400;
    localparam int DEF_MAX_RETRY   = 2;
    localparam int TXSTART_WAIT    = 2;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/n64_tick_gen.sv
// Free-running mod-PERIOD counter; tick is high during the cycle the count wraps.
module n64_tick_gen
    import n64_pkg::*;
#(
    parameter int PERIOD = DEF_POLL_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = cnt_width(PERIOD);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (count_reg == W'(PERIOD - 1)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == W'(PERIOD - 1));

endmodule

// File: rtl/n64_poll_ctrl.sv
// One controller poll per tick: trigger tx, arm rx, latch or retry.
// Optional N64_POLL_STATS_EN adds saturating good_cnt/fail_cnt outputs.
module n64_poll_ctrl
    import n64_pkg::*;
#(
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int RX_TIMEOUT  = DEF_RX_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic                 clk_1M,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic                 tx_trigger,
    input  logic                 tx_busy,
    output logic                 rx_arm,
    input  logic                 rx_done,
    input  logic [RESP_BITS-2:0] rx_data,
    output logic [31:0]          status,
    output logic                 status_valid,
    output logic                 no_ctrl,
    output logic                 busy
`ifdef N64_POLL_STATS_EN
    ,
    output logic [15:0]          good_cnt,
    output logic [15:0]          fail_cnt
`endif
);

    localparam int TW = cnt_width(RX_TIMEOUT + TXSTART_WAIT);
    localparam int RW = cnt_width(MAX_RETRY + 1);

    poll_state_t   state_reg;
    poll_state_t   state_next;
    logic [TW-1:0] timer_reg;
    logic [RW-1:0] retry_reg;
    logic [31:0]   status_reg;
    logic          no_ctrl_reg;
    logic          tick;
    logic          retry_left;

    n64_tick_gen #(
        .PERIOD (POLL_PERIOD)
    ) u_tick (
        .clk   (clk_1M),
        .rst_n (reset_n),
        .tick  (tick)
    );

    assign retry_left = (retry_reg < RW'(MAX_RETRY));

    always_ff @(posedge clk_1M or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (tick && enable) state_next = TRIG;
            TRIG:    state_next = TXSTART;
            TXSTART: begin
                if (tx_busy) begin
                    state_next = TX;
                end else if (timer_reg == TW'(TXSTART_WAIT - 1)) begin
                    state_next = FAIL;
                end
            end
            TX:      if (!tx_busy) state_next = RX;
            RX: begin
                // A response on the last timeout cycle still counts as good.
                if (rx_done) begin
                    state_next = GOOD;
                end else if (timer_reg == TW'(RX_TIMEOUT - 1)) begin
                    state_next = FAIL;
                end
            end
            GOOD:    state_next = IDLE;
            FAIL:    state_next = retry_left ? TRIG : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_trigger   = (state_reg == TRIG);
        rx_arm       = (state_reg == RX);
        status_valid = (state_reg == GOOD);
        busy         = (state_reg != IDLE);
    end

    // Timer restarts on every state change so each waiting state sees 0 on entry.
    always_ff @(posedge clk_1M or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg <= '0;
        end else if ((state_next == state_reg) &&
                     ((state_reg == TXSTART) || (state_reg == RX))) begin
            timer_reg <= timer_reg + 1'b1;
        end else begin
            timer_reg <= '0;
        end
    end

    // rx_data is only valid alongside rx_done, so it is captured on the RX->GOOD edge.
    always_ff @(posedge clk_1M or negedge reset_n) begin
        if (!reset_n) begin
            status_reg  <= '0;
            no_ctrl_reg <= 1'b0;
            retry_reg   <= '0;
        end else begin
            if ((state_reg == RX) && rx_done) begin
                status_reg <= rx_data;
            end
            if (state_reg == GOOD) begin
                no_ctrl_reg <= 1'b0;
                retry_reg   <= '0;
            end else if (state_reg == FAIL) begin
                if (retry_left) begin
                    retry_reg <= retry_reg + 1'b1;
                end else begin
                    retry_reg   <= '0;
                    no_ctrl_reg <= 1'b1;
                end
            end
        end
    end

    assign status  = status_reg;
    assign no_ctrl = no_ctrl_reg;

`ifdef N64_POLL_STATS_EN
    logic [15:0] good_cnt_reg;
    logic [15:0] fail_cnt_reg;

    always_ff @(posedge clk_1M or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt_reg <= '0;
            fail_cnt_reg <= '0;
        end else begin
            if ((state_reg == GOOD) && (good_cnt_reg != 16'hFFFF)) begin
                good_cnt_reg <= good_cnt_reg + 16'd1;
            end
            if ((state_reg == FAIL) && (fail_cnt_reg != 16'hFFFF)) begin
                fail_cnt_reg <= fail_cnt_reg + 16'd1;
            end
        end
    end

    assign good_cnt = good_cnt_reg;
    assign fail_cnt = fail_cnt_reg;
`endif

endmodule
